// File: rtl/shifter_pkg.sv
// Shared constants for the single-bit shifter: default data width and operation codes.
package shifter_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/shifter_unit_if.sv
// Request/result bundle for shifter_unit; the requester holds the master modport.
interface shifter_unit_if #(
  parameter int unsigned WIDTH = shifter_pkg::WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic [1:0]       shift;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;

  modport master (
    output in_valid, in, shift,
    input  out_valid, out, carry, zero
  );

  modport slave (
    input  in_valid, in, shift,
    output out_valid, out, carry, zero
  );

endinterface

// File: rtl/shifter_comb.sv
// Combinational one-bit shifter: pass, logical left, logical right, arithmetic right.
module shifter_comb
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = shifter_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    result = in;
    carry  = 1'b0;
    unique case (shift)
      SH_PASS: begin
        result = in;
        carry  = 1'b0;
      end
      SH_LSL: begin
        result = {in[WIDTH-2:0], 1'b0};
        carry  = in[WIDTH-1];
      end
      SH_LSR: begin
        result = {1'b0, in[WIDTH-1:1]};
        carry  = in[0];
      end
      SH_ASR: begin
        result = {in[WIDTH-1], in[WIDTH-1:1]};
        carry  = in[0];
      end
      default: begin
        result = in;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shifter_unit.sv
// Registered one-cycle-latency shifter; outputs hold their last result while no request arrives.
module shifter_unit
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = shifter_pkg::WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  shifter_unit_if.slave  bus
);

  logic [WIDTH-1:0] comb_result;
  logic             comb_carry;

  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             zero_q;

  shifter_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .in     (bus.in),
    .shift  (bus.shift),
    .result (comb_result),
    .carry  (comb_carry)
  );

  // Reset wins over a simultaneous request; idle cycles leave the result registers untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_q   <= comb_result;
        carry_q <= comb_carry;
        zero_q  <= ~|comb_result;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: directed vector table, reset/idle sequences, random run.
module tb_shifter_unit;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  shifter_unit_if #(.WIDTH(16)) bus ();

  shifter_unit #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [1:0]  sh;
    logic [15:0] exp_out;
    logic        exp_carry;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[16];

  // Expected-state tracking for the random phase.
  logic [15:0] m_out;
  logic        m_carry;
  logic        m_zero;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic v, input logic [15:0] o,
                           input logic c, input logic z);
    chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, ".out"}, {16'd0, bus.out}, {16'd0, o});
    chk({tag, ".carry"}, {31'd0, bus.carry}, {31'd0, c});
    chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
  endtask

  // Reference computed with integer arithmetic on the operand value.
  task automatic model(input logic [15:0] a, input logic [1:0] sh,
                       output logic [15:0] r, output logic c);
    int unsigned v;
    int unsigned res;
    v = 32'(a);
    case (sh)
      2'd1: begin res = (v * 2) % 65536; c = (v >= 32768); end
      2'd2: begin res = v / 2;           c = (v % 2) == 1; end
      2'd3: begin res = v / 2 + ((v >= 32768) ? 32768 : 0); c = (v % 2) == 1; end
      default: begin res = v;            c = 1'b0; end
    endcase
    r = res[15:0];
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{16'hF0CF, 2'b01, 16'hE19E, 1'b1, 1'b0};
    vecs[1]  = '{16'hF0CF, 2'b10, 16'h7867, 1'b1, 1'b0};
    vecs[2]  = '{16'hF0CF, 2'b11, 16'hF867, 1'b1, 1'b0};
    vecs[3]  = '{16'hF0CF, 2'b00, 16'hF0CF, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFFF, 2'b01, 16'hFFFE, 1'b1, 1'b0};
    vecs[5]  = '{16'hFFFF, 2'b10, 16'h7FFF, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 2'b11, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'hFFFF, 2'b00, 16'hFFFF, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 2'b00, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{16'h0000, 2'b01, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{16'h0000, 2'b10, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{16'h0000, 2'b11, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{16'h0001, 2'b01, 16'h0002, 1'b0, 1'b0};
    vecs[13] = '{16'h0001, 2'b10, 16'h0000, 1'b1, 1'b1};
    vecs[14] = '{16'h0001, 2'b11, 16'h0000, 1'b1, 1'b1};
    vecs[15] = '{16'h0001, 2'b00, 16'h0001, 1'b0, 1'b0};

    // Reset with a live request: the request must be discarded.
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in       = 16'hFFFF;
    bus.shift    = 2'b01;
    step();
    step();
    check_all("reset", 1'b0, 16'h0000, 1'b0, 1'b1);

    // First edge with reset released accepts the request.
    rst_n = 1'b1;
    step();
    check_all("first_req", 1'b1, 16'hFFFE, 1'b1, 1'b0);

    // Back-to-back directed vectors, no bubbles.
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in       = vecs[i].a;
      bus.shift    = vecs[i].sh;
      step();
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].exp_out, vecs[i].exp_carry,
                vecs[i].exp_zero);
    end

    // Single request then idle: result held, valid for one cycle only.
    bus.in_valid = 1'b1;
    bus.in       = 16'h8001;
    bus.shift    = 2'b11;
    step();
    check_all("asr8001", 1'b1, 16'hC000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b0;
      bus.in       = 16'($urandom);
      bus.shift    = 2'($urandom);
      step();
      check_all($sformatf("hold%0d", i), 1'b0, 16'hC000, 1'b1, 1'b0);
    end

    // Random phase with occasional reset.
    m_out   = 16'hC000;
    m_carry = 1'b1;
    m_zero  = 1'b0;
    m_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [15:0] r;
      logic        c;
      rst_n        = ($urandom_range(0, 29) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in       = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      bus.shift    = 2'($urandom);
      model(bus.in, bus.shift, r, c);
      if (!rst_n) begin
        m_out = 16'h0000; m_carry = 1'b0; m_zero = 1'b1; m_valid = 1'b0;
      end else if (bus.in_valid) begin
        m_out = r; m_carry = c; m_zero = (r == 16'h0000); m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      step();
      check_all($sformatf("rnd%0d", i), m_valid, m_out, m_carry, m_zero);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
